sbox_bdd: RTL and testbench
===========================

Name: sbox_bdd

Overview:
- Merged AES S-box / inverse S-box (FIPS-197 SubBytes / InvSubBytes) for a single byte.
- Built as a binary-decision-diagram (multiplexer-tree) network, with `encrypt` as a decision variable shared across both tables.
- Used as the byte-substitution primitive in AES round datapaths and key expansion.
- Zero-latency combinational by default; an output register can be compiled in.

Parameters:
- None. Width is fixed at 8 bits.

Ports:
- clk  input  1  clock; used only when SBOX_BDD_OUT_REG_EN is defined.
- rst_n  input  1  asynchronous active-low reset.
- encrypt  input  1  1 = forward S-box, 0 = inverse S-box.
- byte_in  input  8  byte to substitute.
- byte_out  output  8  substituted byte.

Behaviour:
- encrypt=1: byte_out = SBOX[byte_in], the FIPS-197 forward table.
- encrypt=0: byte_out = INV_SBOX[byte_in], the FIPS-197 inverse table.
- Structure:
  - Each output bit is a reduced, ordered decision tree (2:1 muxes) over byte_in[7:0] and encrypt.
  - Isomorphic subtrees are shared between output bits and between the two tables.
  - Leaves are constants 0/1.
  - No ROM/case table inference, no GF arithmetic.
- Reset:
  - While rst_n=0, byte_out = 0x00 asynchronously, regardless of clk.
  - On rst_n release, byte_out reflects the current inputs. Combinational mode: immediate. Register mode: at the next rising clk.
- Default (macro undefined):
  - Purely combinational from byte_in/encrypt to byte_out; latency 0.
  - Output settles within one combinational delay of any input change; no clock dependency.
  - clk is unused.
- Mode switch: toggling encrypt with byte_in held selects the other table with the same latency as a byte_in change.
- Output must never be X/Z for any known 0/1 input combination; all 512 combinations are defined.
- No internal state other than the optional output register.

Optional Feature:
- SBOX_BDD_OUT_REG_EN defined:
  - byte_out is registered on the rising edge of clk; latency 1 cycle.
  - The register is asynchronously cleared to 0x00 when rst_n=0.
  - A new result is captured every cycle; full throughput.
- Undefined: combinational behaviour as above, with the rst_n output gating retained.

Test Plan:
- rst_n=1, encrypt=1, sweep byte_in 0x00..0xFF -> every byte_out matches FIPS-197 SBOX. Spot checks: 00->63, 01->7C, 53->ED, FF->16.
- rst_n=1, encrypt=0, sweep byte_in 0x00..0xFF -> every byte_out matches INV_SBOX. Spot checks: 00->52, 63->00, ED->53, FF->7D.
- Round trip: for all x, apply SBOX with encrypt=1, feed the result back with encrypt=0 -> output equals x.
- byte_in=0x53 held, toggle encrypt 1->0 -> byte_out ED->50 with no X at settled time.
- Assert rst_n=0 mid-sweep with byte_in=0x01, encrypt=1 -> byte_out=0x00 immediately. Release -> 0x7C (next edge when the register is enabled).
- With SBOX_BDD_OUT_REG_EN: byte_in stream 00,01,53 at successive rising edges -> byte_out 63,7C,ED, each one cycle later.

Source files
------------

// File: rtl/sbox_bdd.sv
// Merged AES S-box / inverse S-box built as an ordered 2:1 multiplexer decision tree.
// Define SBOX_BDD_OUT_REG_EN to register byte_out (one cycle of latency).
module sbox_bdd (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       encrypt,
    input  logic [7:0] byte_in,
    output logic [7:0] byte_out
);

    // Forward substitution table, row-major, entry 0x00 in the most significant byte.
    localparam logic [2047:0] FWD = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Leaf constants indexed by {encrypt, byte_in}; the inverse half is derived
    // from the forward half so the two tables cannot disagree.
    function automatic logic [511:0][7:0] build_leaves();
        logic [511:0][7:0] t;
        logic [7:0]        s;
        t = '0;
        for (int x = 0; x < 256; x++) begin
            s = FWD[2047 - 8*x -: 8];
            t[256 + x]    = s;
            t[{1'b0, s}]  = 8'(x);
        end
        return t;
    endfunction

    localparam logic [511:0][7:0] LEAVES = build_leaves();

    // Decision order from the leaves upward: byte_in[0] .. byte_in[7], then encrypt.
    // Constant leaves let synthesis fold isomorphic subtrees across all output
    // bits and both tables, leaving a reduced shared mux network.
    logic [7:0] n1 [256];
    logic [7:0] n2 [128];
    logic [7:0] n3 [64];
    logic [7:0] n4 [32];
    logic [7:0] n5 [16];
    logic [7:0] n6 [8];
    logic [7:0] n7 [4];
    logic [7:0] n8 [2];
    logic [7:0] root;

    for (genvar j = 0; j < 256; j++) begin : g_l1
        assign n1[j] = byte_in[0] ? LEAVES[2*j + 1] : LEAVES[2*j];
    end
    for (genvar j = 0; j < 128; j++) begin : g_l2
        assign n2[j] = byte_in[1] ? n1[2*j + 1] : n1[2*j];
    end
    for (genvar j = 0; j < 64; j++) begin : g_l3
        assign n3[j] = byte_in[2] ? n2[2*j + 1] : n2[2*j];
    end
    for (genvar j = 0; j < 32; j++) begin : g_l4
        assign n4[j] = byte_in[3] ? n3[2*j + 1] : n3[2*j];
    end
    for (genvar j = 0; j < 16; j++) begin : g_l5
        assign n5[j] = byte_in[4] ? n4[2*j + 1] : n4[2*j];
    end
    for (genvar j = 0; j < 8; j++) begin : g_l6
        assign n6[j] = byte_in[5] ? n5[2*j + 1] : n5[2*j];
    end
    for (genvar j = 0; j < 4; j++) begin : g_l7
        assign n7[j] = byte_in[6] ? n6[2*j + 1] : n6[2*j];
    end
    for (genvar j = 0; j < 2; j++) begin : g_l8
        assign n8[j] = byte_in[7] ? n7[2*j + 1] : n7[2*j];
    end

    assign root = encrypt ? n8[1] : n8[0];

`ifdef SBOX_BDD_OUT_REG_EN
    logic [7:0] byte_out_p1;

    // Stage p1: registered result, cleared asynchronously while in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            byte_out_p1 <= '0;
        end else begin
            byte_out_p1 <= root;
        end
    end

    assign byte_out = byte_out_p1;
`else
    logic clk_unused;

    assign clk_unused = clk;
    assign byte_out   = rst_n ? root : 8'h00;
`endif

endmodule

// File: tb/tb_sbox_bdd.sv
// Self-checking bench for sbox_bdd against a GF(2^8) reference model; honours SBOX_BDD_OUT_REG_EN.
module tb_sbox_bdd;

`ifdef SBOX_BDD_OUT_REG_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 0;
`endif

    logic       clk;
    logic       rst_n;
    logic       encrypt;
    logic [7:0] byte_in;
    logic [7:0] byte_out;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    int cyc    = 0;

    typedef struct packed {
        int         due;
        logic [7:0] exp;
        logic       enc;
        logic [7:0] din;
    } sb_t;

    sb_t        sb[$];
    logic [7:0] fwd_tab [256];
    logic [7:0] inv_tab [256];

    sbox_bdd dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .encrypt  (encrypt),
        .byte_in  (byte_in),
        .byte_out (byte_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p, aa, bb;
        logic       hi;
        p  = 8'h00;
        aa = a;
        bb = b;
        for (int i = 0; i < 8; i++) begin
            if (bb[0]) p = p ^ aa;
            hi = aa[7];
            aa = aa << 1;
            if (hi) aa = aa ^ 8'h1b;
            bb = bb >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int k);
        return (v << k) | (v >> (8 - k));
    endfunction

    function automatic logic [7:0] model_sbox(input logic [7:0] x);
        logic [7:0] inv;
        inv = 8'h00;
        for (int b = 1; b < 256; b++) begin
            if (x != 8'h00 && gmul(x, 8'(b)) == 8'h01) inv = 8'(b);
        end
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    task automatic check(input logic [7:0] obs, input logic [7:0] exp, input string tag);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Push the expected value when the stimulus is applied.
    task automatic drive(input logic e, input logic [7:0] b, input logic [7:0] exp);
        sb_t item;
        @(posedge clk);
        #1;
        encrypt = e;
        byte_in = b;
        item.due = cyc + LAT;
        item.exp = exp;
        item.enc = e;
        item.din = b;
        sb.push_back(item);
    endtask

    task automatic drain();
        repeat (LAT + 2) @(posedge clk);
    endtask

    // Scoreboard: pop and compare entries whose result is due this cycle.
    always @(negedge clk) begin
        sb_t item;
        while (sb.size() > 0 && sb[0].due == cyc) begin
            item = sb.pop_front();
            check(byte_out, item.exp, $sformatf("sb enc=%0d in=%02h", item.enc, item.din));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] y;

        for (int x = 0; x < 256; x++) fwd_tab[x] = model_sbox(8'(x));
        for (int x = 0; x < 256; x++) inv_tab[fwd_tab[x]] = 8'(x);

        rst_n   = 1'b0;
        encrypt = 1'b1;
        byte_in = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        check(byte_out, 8'h00, "reset_state");
        byte_in = 8'h53;
        #1;
        check(byte_out, 8'h00, "reset_input_change");
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        drive(1'b1, 8'h00, 8'h63);
        drive(1'b1, 8'h01, 8'h7c);
        drive(1'b1, 8'h53, 8'hed);
        drive(1'b1, 8'hff, 8'h16);
        drive(1'b0, 8'h00, 8'h52);
        drive(1'b0, 8'h63, 8'h00);
        drive(1'b0, 8'hed, 8'h53);
        drive(1'b0, 8'hff, 8'h7d);

        drive(1'b1, 8'h53, 8'hed);
        drive(1'b0, 8'h53, 8'h50);

        for (int x = 0; x < 128; x++) drive(1'b1, 8'(x), fwd_tab[x]);

        drain();
        @(posedge clk);
        #1;
        encrypt = 1'b1;
        byte_in = 8'h01;
        rst_n   = 1'b0;
        #1;
        check(byte_out, 8'h00, "rst_async_assert");
        @(posedge clk);
        #1;
        check(byte_out, 8'h00, "rst_held_over_edge");
        rst_n = 1'b1;
        #1;
`ifdef SBOX_BDD_OUT_REG_EN
        check(byte_out, 8'h00, "rst_release_before_edge");
        @(posedge clk);
        #1;
`endif
        check(byte_out, 8'h7c, "rst_release");

        for (int x = 128; x < 256; x++) drive(1'b1, 8'(x), fwd_tab[x]);
        for (int x = 0; x < 256; x++) drive(1'b0, 8'(x), inv_tab[x]);

        for (int x = 0; x < 256; x++) begin
            drive(1'b1, 8'(x), fwd_tab[x]);
            repeat (LAT) @(posedge clk);
            @(negedge clk);
            y = byte_out;
            drive(1'b0, y, 8'(x));
        end

        drain();
        checks++;
        assert (sb.size() == 0) passes++;
        else begin
            fails++;
            $error("FAIL scoreboard_drain: observed %0d pending expected 0", sb.size());
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
